cdb_arbiter: RTL and testbench

Common Data Bus arbiter for the Tomasulo datapath. Each functional unit (R-type ALU, load/store, branch) offers its finished result (value plus reservation-station tag) through a valid/ready handshake into a private one-entry holding slot. The arbiter grants one full slot per cycle, round-robin, and drives a registered single-cycle broadcast onto the CDB, which the reservation stations and the register status table snoop.

---
 rtl/cdb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common Data Bus arbiter for the Tomasulo datapath. Every functional unit
// hands its finished result (value + reservation-station tag) over a
// valid/ready handshake into a private one-entry slot. Each cycle one full
// slot is granted and its contents are broadcast on the CDB as a registered,
// single-cycle pulse that the reservation stations and the register status
// table snoop.
//
// Build option:
//   CDB_ARB_FIXED_PRIO_EN  defined   -> lowest-index full slot always wins
//                                       (unit 0, the R-type ALU, has priority);
//                                       no round-robin pointer exists.
//                          undefined -> round-robin search starting at ptr.
//
// Parameters:
//   N_REQ   number of requesting units (2..8)
//   DATA_W  result width
//   TAG_W   reservation-station tag width (tag 0 = no producer)
//
// Ports:
//   Clock      in   rising-edge clock
//   Resetn     in   asynchronous active-low reset
//   Req        in   [N_REQ]         unit i offers a result
//   Data       in   [N_REQ*DATA_W]  unit i value at [i*DATA_W +: DATA_W]
//   Tag        in   [N_REQ*TAG_W]   unit i tag at [i*TAG_W +: TAG_W]
//   Ready      out  [N_REQ]         combinational; slot i accepts this cycle
//   Stall      in                   CDB consumers cannot take a broadcast
//   CDB_Valid  out                  registered broadcast valid
//   CDB_Data   out  [DATA_W]        registered broadcast value
//   CDB_Tag    out  [TAG_W]         registered broadcast tag
//   CDB_Src    out  [3]             registered index of the granted unit
//   Pending    out  [N_REQ]         registered slot-full flags
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*DATA_W-1:0] Data,
  input  logic [N_REQ*TAG_W-1:0]  Tag,
  output logic [N_REQ-1:0]        Ready,
  input  logic                    Stall,
  output logic                    CDB_Valid,
  output logic [DATA_W-1:0]       CDB_Data,
  output logic [TAG_W-1:0]        CDB_Tag,
  output logic [2:0]              CDB_Src,
  output logic [N_REQ-1:0]        Pending
);

  // Unpacked views of the flat input buses
  logic [DATA_W-1:0] req_data [N_REQ];
  logic [TAG_W-1:0]  req_tag  [N_REQ];

  // Slot storage and state
  logic [DATA_W-1:0] slot_data_reg [N_REQ];
  logic [TAG_W-1:0]  slot_tag_reg  [N_REQ];
  logic [N_REQ-1:0]  pending_reg;
  logic [N_REQ-1:0]  pending_next;

  logic              cdb_valid_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [TAG_W-1:0]  cdb_tag_reg;
  logic [2:0]        cdb_src_reg;

  // Arbitration
  logic [N_REQ-1:0]  grant;
  logic [2:0]        grant_idx;
  logic              grant_found;
  logic              fire;
  logic [N_REQ-1:0]  accept;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [2:0]        ptr_reg;
`endif

  // ---------------------------------------------------------------------------
  // Grant search. Round-robin is done as two linear passes: the first only
  // considers slots at or above ptr, the second (reached only if the first
  // found nothing) takes the lowest full slot, which is the wrapped part of
  // the search. The fixed-priority build is just the second pass.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
`ifndef CDB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && pending_reg[i] && (3'(i) >= ptr_reg)) begin
        grant_found = 1'b1;
        grant_idx   = 3'(i);
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && pending_reg[i]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_found && (3'(i) == grant_idx);
      if (grant[i]) begin
        sel_data = slot_data_reg[i];
        sel_tag  = slot_tag_reg[i];
      end
    end
  end

  assign fire = grant_found & ~Stall;

  // Ready never looks at Req, so a unit may gate Req on Ready without a loop.
  assign Ready  = ~pending_reg | (grant & {N_REQ{~Stall}});
  assign accept = Req & Ready;

  // ---------------------------------------------------------------------------
  // Per-slot unpacking and next-state. An accepted result takes precedence
  // over the clear from a same-edge broadcast (refill); a tag-0 result is
  // accepted but leaves the slot empty so it is never broadcast.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign req_data[gi] = Data[gi*DATA_W +: DATA_W];
      assign req_tag[gi]  = Tag[gi*TAG_W +: TAG_W];
      assign pending_next[gi] = accept[gi] ? (|req_tag[gi])
                                           : (pending_reg[gi] & ~(fire & grant[gi]));
    end
  endgenerate

  // Slot payload needs no reset: it is only observed while Pending is set.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_data_reg[i] <= req_data[i];
        slot_tag_reg[i]  <= req_tag[i];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pending_reg   <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_data_reg  <= '0;
      cdb_tag_reg   <= '0;
      cdb_src_reg   <= '0;
    end else begin
      pending_reg   <= pending_next;
      cdb_valid_reg <= fire;
      // On a stalled or idle edge the bus payload holds its last value.
      if (fire) begin
        cdb_data_reg <= sel_data;
        cdb_tag_reg  <= sel_tag;
        cdb_src_reg  <= grant_idx;
      end
    end
  end

`ifndef CDB_ARB_FIXED_PRIO_EN
  // Pointer moves just past the slot that was broadcast.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr_reg <= 3'd0;
    end else if (fire) begin
      ptr_reg <= (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end
`endif

  assign CDB_Valid = cdb_valid_reg;
  assign CDB_Data  = cdb_data_reg;
  assign CDB_Tag   = cdb_tag_reg;
  assign CDB_Src   = cdb_src_reg;
  assign Pending   = pending_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter (N_REQ=4, DATA_W=16, TAG_W=3). The stimulus
// process pushes each expected broadcast into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever CDB_Valid is high, and
// flags any broadcast that was not expected.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  logic                    Clock;
  logic                    Resetn;
  logic [N_REQ-1:0]        Req;
  logic [N_REQ*DATA_W-1:0] Data;
  logic [N_REQ*TAG_W-1:0]  Tag;
  logic [N_REQ-1:0]        Ready;
  logic                    Stall;
  logic                    CDB_Valid;
  logic [DATA_W-1:0]       CDB_Data;
  logic [TAG_W-1:0]        CDB_Tag;
  logic [2:0]              CDB_Src;
  logic [N_REQ-1:0]        Pending;

  cdb_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Req       (Req),
    .Data      (Data),
    .Tag       (Tag),
    .Ready     (Ready),
    .Stall     (Stall),
    .CDB_Valid (CDB_Valid),
    .CDB_Data  (CDB_Data),
    .CDB_Tag   (CDB_Tag),
    .CDB_Src   (CDB_Src),
    .Pending   (Pending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        src;
  } bcast_t;

  bcast_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %-14s ok   got=%0h", name, act);
    end else begin
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t, input logic [2:0] s);
    bcast_t e;
    e.data = d;
    e.tag  = t;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic set_unit(input int u, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    Data[u*DATA_W +: DATA_W] = d;
    Tag[u*TAG_W +: TAG_W]    = t;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (Resetn && CDB_Valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bcast_unexpected: got data=%h tag=%0d src=%0d, required no broadcast",
                 CDB_Data, CDB_Tag, CDB_Src);
      end else begin
        bcast_t e;
        e = exp_q.pop_front();
        if (CDB_Data === e.data && CDB_Tag === e.tag && CDB_Src === e.src) begin
          n_pass++;
          $display("bcast ok   data=%h tag=%0d src=%0d", CDB_Data, CDB_Tag, CDB_Src);
        end else begin
          $display("FAIL bcast: got data=%h tag=%0d src=%0d required data=%h tag=%0d src=%0d",
                   CDB_Data, CDB_Tag, CDB_Src, e.data, e.tag, e.src);
        end
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    Req    = '0;
    Data   = '0;
    Tag    = '0;
    Stall  = 1'b0;

    // ---- Reset with all units requesting
    Req = 4'b1111;
    for (int u = 0; u < N_REQ; u++) set_unit(u, 16'h1234, 3'd1);
    repeat (2) cyc();
    check("rst_ready", Ready, 4'b1111);
    check("rst_valid", CDB_Valid, 1'b0);
    check("rst_pending", Pending, 4'b0000);
    check("rst_data", CDB_Data, 16'h0000);
    Req    = '0;
    Resetn = 1'b1;
    cyc();
    check("post_rst_pend", Pending, 4'b0000);

    // ---- Single transfer on unit 2
    Req = 4'b0100;
    set_unit(2, 16'h00AB, 3'd3);
    push(16'h00AB, 3'd3, 3'd2);
    #1 check("single_ready", Ready, 4'b1111);
    cyc();                                   // E0
    Req = '0;
    #1 check("single_pend", Pending, 4'b0100);
    check("single_lat", CDB_Valid, 1'b0);
    cyc();                                   // E1: broadcast
    check("single_clr", Pending, 4'b0000);
    check("single_vld", CDB_Valid, 1'b1);
    cyc();
    check("single_pulse", CDB_Valid, 1'b0);
    check("single_hold", CDB_Data, 16'h00AB);

    // ---- Unit 3 once (moves the round-robin pointer back to 0)
    Req = 4'b1000;
    set_unit(3, 16'h3333, 3'd7);
    push(16'h3333, 3'd7, 3'd3);
    cyc();
    Req = '0;
    repeat (2) cyc();

    // ---- Fill all four slots in one edge
    Req = 4'b1111;
    set_unit(0, 16'hA000, 3'd1);
    set_unit(1, 16'hA111, 3'd2);
    set_unit(2, 16'hA222, 3'd3);
    set_unit(3, 16'hA333, 3'd4);
    push(16'hA000, 3'd1, 3'd0);
    push(16'hA111, 3'd2, 3'd1);
    push(16'hA222, 3'd3, 3'd2);
    push(16'hA333, 3'd4, 3'd3);
    cyc();
    Req = '0;
    #1 check("rr_fill", Pending, 4'b1111);
    check("rr_full_ready", Ready, 4'b0001);
    repeat (4) cyc();
    check("rr_drained", Pending, 4'b0000);

    // ---- Unit 1 once, then refill slots 0 and 3 on its broadcast edge
    Req = 4'b0010;
    set_unit(1, 16'h6666, 3'd6);
    push(16'h6666, 3'd6, 3'd1);
    cyc();
    Req = 4'b1001;
    set_unit(0, 16'hB000, 3'd2);
    set_unit(3, 16'hB333, 3'd3);
`ifdef CDB_ARB_FIXED_PRIO_EN
    push(16'hB000, 3'd2, 3'd0);
    push(16'hB333, 3'd3, 3'd3);
`else
    push(16'hB333, 3'd3, 3'd3);
    push(16'hB000, 3'd2, 3'd0);
`endif
    #1 check("refill_ready", Ready, 4'b1111);
    cyc();
    Req = '0;
    #1 check("refill_pend", Pending, 4'b1001);
    repeat (3) cyc();
    check("refill_drain", Pending, 4'b0000);

    // ---- Stall for three cycles with slot 1 full
    Req   = 4'b0010;
    Stall = 1'b1;
    set_unit(1, 16'h2222, 3'd2);
    #1 check("stall_acc_rdy", {31'd0, Ready[1]}, 32'd1);
    cyc();
    Req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", CDB_Valid, 1'b0);
      check("stall_ready1", {31'd0, Ready[1]}, 32'd0);
      check("stall_pend", Pending, 4'b0010);
      cyc();
    end
    Stall = 1'b0;
    Req   = 4'b0010;
    set_unit(1, 16'h5555, 3'd5);
    push(16'h2222, 3'd2, 3'd1);
    push(16'h5555, 3'd5, 3'd1);
    #1 check("unstall_ready1", {31'd0, Ready[1]}, 32'd1);
    cyc();
    Req = '0;
    #1 check("b2b_pend", Pending, 4'b0010);
    cyc();
    check("b2b_clr", Pending, 4'b0000);

    // ---- Tag-0 result is swallowed
    Req = 4'b0001;
    set_unit(0, 16'hDEAD, 3'd0);
    #1 check("tag0_ready", {31'd0, Ready[0]}, 32'd1);
    cyc();
    Req = '0;
    #1 check("tag0_pend", Pending, 4'b0000);
    repeat (2) cyc();
    check("tag0_nobcast", CDB_Valid, 1'b0);

    // ---- Mid-operation reset with two slots still full
    Req = 4'b0111;
    set_unit(0, 16'hC000, 3'd1);
    set_unit(1, 16'hC111, 3'd2);
    set_unit(2, 16'hC222, 3'd3);
    cyc();
    Req = '0;
    #1 check("mid_fill", Pending, 4'b0111);
`ifdef CDB_ARB_FIXED_PRIO_EN
    push(16'hC000, 3'd1, 3'd0);
`else
    push(16'hC222, 3'd3, 3'd2);
`endif
    cyc();
`ifdef CDB_ARB_FIXED_PRIO_EN
    check("mid_left", Pending, 4'b0110);
`else
    check("mid_left", Pending, 4'b0011);
`endif
    #5;                                      // past the falling edge
    Resetn = 1'b0;
    #1;
    check("mid_rst_pend", Pending, 4'b0000);
    check("mid_rst_valid", CDB_Valid, 1'b0);
    check("mid_rst_ready", Ready, 4'b1111);
    Resetn = 1'b1;
    repeat (4) cyc();
    check("post_mid_pend", Pending, 4'b0000);
    check("post_mid_vld", CDB_Valid, 1'b0);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
